// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

    // Frame sequencer states; the machine advances only on a keyboard clock fall.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    // Prefix bytes that are folded into flags instead of producing records.
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // One decoded key event as presented to the consumer.
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_rec_t;

endpackage

// File: rtl/ps2_code_fifo.sv
// Synchronous record FIFO. DEPTH must be a power of two, at least 2.
// The caller guarantees push only when not full (or together with a pop)
// and pop only when not empty.
module ps2_code_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push_i,
    input  logic     pop_i,
    input  ps2_rec_t rec_i,
    output ps2_rec_t rec_o,
    output logic     full_o,
    output logic     empty_o
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    ps2_rec_t    mem_q [DEPTH];

    // Pointer advance on each accepted push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage array; contents are meaningless while empty so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= rec_i;
    end

    assign rec_o   = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard receive controller: frames 11-bit packets from the debounced
// clock/data lines, folds E0/F0 prefixes into flags and buffers records.
// Build option: define PS2_RX_FIFO_EN for a FIFO_DEPTH-entry record FIFO;
// otherwise a single holding register buffers one record.
//
// Output handshake: a record is transferred in any cycle where code_valid and
// code_ready are both 1; while code_valid=1 and no transfer occurs, code_data,
// code_ext and code_brk hold steady; code_ready with code_valid=0 is ignored.
module ps2_rx_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_db,
    input  logic       ps2_data_db,
    output logic [7:0] code_data,
    output logic       code_ext,
    output logic       code_brk,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       overflow,
    output ps2_state_e state_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    ps2_state_e    state_q;
    logic          clk_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shreg_q;
    logic          par_q;
    logic          ext_q;
    logic          brk_q;
    logic [TW-1:0] to_cnt_q;
    logic          push_q;
    ps2_rec_t      push_rec_q;
    logic          err_parity_q;
    logic          err_frame_q;
    logic          overflow_q;

    logic          fall;
    logic          pop;
    logic          wr_en;
    logic          have_rec;
    logic          buf_full;
    ps2_rec_t      head_rec;

    assign fall = clk_q & ~ps2_clk_db;

    // Frame sequencer, timeout, prefix decode and registered error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            clk_q        <= 1'b1;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            to_cnt_q     <= '0;
            push_q       <= 1'b0;
            push_rec_q   <= '0;
            err_parity_q <= 1'b0;
            err_frame_q  <= 1'b0;
        end else begin
            clk_q        <= ps2_clk_db;
            push_q       <= 1'b0;
            err_parity_q <= 1'b0;
            err_frame_q  <= 1'b0;

            if (fall || state_q == IDLE) to_cnt_q <= '0;
            else                         to_cnt_q <= to_cnt_q + 1'b1;

            if (fall) begin
                case (state_q)
                    IDLE: begin
                        if (!ps2_data_db) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            err_frame_q <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg_q   <= {ps2_data_db, shreg_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        par_q   <= ps2_data_db;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (ps2_data_db && (^shreg_q ^ par_q)) begin
                            if (shreg_q == PS2_EXT) begin
                                ext_q <= 1'b1;
                            end else if (shreg_q == PS2_BRK) begin
                                brk_q <= 1'b1;
                            end else begin
                                push_q     <= 1'b1;
                                push_rec_q <= '{ext: ext_q, brk: brk_q, code: shreg_q};
                                ext_q      <= 1'b0;
                                brk_q      <= 1'b0;
                            end
                        end else begin
                            err_parity_q <= 1'b1;
                            ext_q        <= 1'b0;
                            brk_q        <= 1'b0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end else if (state_q != IDLE && to_cnt_q == TO_LAST) begin
                state_q     <= IDLE;
                err_frame_q <= 1'b1;
                ext_q       <= 1'b0;
                brk_q       <= 1'b0;
            end
        end
    end

    assign pop   = have_rec & code_ready;
    assign wr_en = push_q & (~buf_full | pop);

    // Overflow pulse when a finished record meets a full buffer with no pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow_q <= 1'b0;
        else     overflow_q <= push_q & buf_full & ~pop;
    end

`ifdef PS2_RX_FIFO_EN
    logic fifo_empty;

    ps2_code_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_en),
        .pop_i   (pop),
        .rec_i   (push_rec_q),
        .rec_o   (head_rec),
        .full_o  (buf_full),
        .empty_o (fifo_empty)
    );

    assign have_rec = ~fifo_empty;
`else
    logic     hold_valid_q;
    ps2_rec_t hold_rec_q;
    logic [31:0] unused_depth;

    assign unused_depth = FIFO_DEPTH;

    // Single-entry holding register; a write in the same cycle as a pop refills it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_rec_q   <= '0;
        end else if (wr_en) begin
            hold_valid_q <= 1'b1;
            hold_rec_q   <= push_rec_q;
        end else if (pop) begin
            hold_valid_q <= 1'b0;
        end
    end

    assign have_rec = hold_valid_q;
    assign buf_full = hold_valid_q;
    assign head_rec = hold_rec_q;
`endif

    assign code_valid = have_rec;
    assign code_data  = have_rec ? head_rec.code : 8'h00;
    assign code_ext   = have_rec & head_rec.ext;
    assign code_brk   = have_rec & head_rec.brk;
    assign err_parity = err_parity_q;
    assign err_frame  = err_frame_q;
    assign overflow   = overflow_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Bench for ps2_rx_ctrl; expected buffer depth follows PS2_RX_FIFO_EN.
module tb_ps2_rx_ctrl;
    import ps2_pkg::*;

    localparam int TO   = 200;
    localparam int HALF = 20;
`ifdef PS2_RX_FIFO_EN
    localparam int EFF_DEPTH = 4;
`else
    localparam int EFF_DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk_db;
    logic       ps2_data_db;
    logic [7:0] code_data;
    logic       code_ext;
    logic       code_brk;
    logic       code_valid;
    logic       code_ready;
    logic       err_parity;
    logic       err_frame;
    logic       overflow;
    ps2_state_e state_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_perr   = 0;
    int n_ferr   = 0;
    int n_ovf    = 0;

    logic [9:0] exp_q[$];

    typedef struct {
        logic [7:0] code;
        bit         bad_par;
        bit         exp_rec;
        logic [9:0] rec;
        int         exp_perr;
    } vec_t;

    vec_t vecs[15];

    ps2_rx_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_db  (ps2_clk_db),
        .ps2_data_db (ps2_data_db),
        .code_data   (code_data),
        .code_ext    (code_ext),
        .code_brk    (code_brk),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .err_parity  (err_parity),
        .err_frame   (err_frame),
        .overflow    (overflow),
        .state_o     (state_o)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first nbits bits of a frame (start, 8 data, parity, stop).
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits,
                              input bit check_lat);
        logic        par;
        logic [10:0] frame;
        par   = ~(^b) ^ bad_par;
        frame = {1'b1, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data_db = frame[i];
            step(HALF / 2);
            ps2_clk_db = 1'b0;
            if (check_lat && i == 10) begin
                step(1);
                chk("latency_before", code_valid, 0);
                step(1);
                chk("latency_rise", code_valid, 1);
                step(HALF - 2);
            end else begin
                step(HALF);
            end
            ps2_clk_db = 1'b1;
            step(HALF / 2);
        end
        ps2_data_db = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) step(1);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Scoreboard: compares each accepted record and checks hold stability.
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [9:0] prev_rec   = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (err_parity) n_perr++;
            if (err_frame)  n_ferr++;
            if (overflow)   n_ovf++;
            if (prev_valid && !prev_ready)
                chk("hold_stable", {code_valid, code_ext, code_brk, code_data}, {1'b1, prev_rec});
            if (code_valid && code_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_record", {code_ext, code_brk, code_data}, 10'h3FF);
                end else begin
                    chk("record", {code_ext, code_brk, code_data}, exp_q.pop_front());
                end
            end
            prev_valid <= code_valid;
            prev_ready <= code_ready;
            prev_rec   <= {code_ext, code_brk, code_data};
        end
    end

    initial begin
        int p0;
        int f0;
        int o0;

        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 10'h01C, 0};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 0};
        vecs[2]  = '{8'h1C, 1'b0, 1'b1, 10'h11C, 0};
        vecs[3]  = '{8'hE0, 1'b0, 1'b0, 10'h000, 0};
        vecs[4]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 0};
        vecs[5]  = '{8'h75, 1'b0, 1'b1, 10'h375, 0};
        vecs[6]  = '{8'h1C, 1'b1, 1'b0, 10'h000, 1};
        vecs[7]  = '{8'h1C, 1'b0, 1'b1, 10'h01C, 0};
        vecs[8]  = '{8'hF0, 1'b0, 1'b0, 10'h000, 0};
        vecs[9]  = '{8'h1C, 1'b1, 1'b0, 10'h000, 1};
        vecs[10] = '{8'h1C, 1'b0, 1'b1, 10'h01C, 0};
        vecs[11] = '{8'hE0, 1'b0, 1'b0, 10'h000, 0};
        vecs[12] = '{8'hE0, 1'b0, 1'b0, 10'h000, 0};
        vecs[13] = '{8'h12, 1'b0, 1'b1, 10'h212, 0};
        vecs[14] = '{8'h5A, 1'b0, 1'b1, 10'h05A, 0};

        // Reset state.
        rst         = 1'b1;
        ps2_clk_db  = 1'b1;
        ps2_data_db = 1'b1;
        code_ready  = 1'b1;
        step(3);
        chk("rst_valid", code_valid, 0);
        chk("rst_data", code_data, 0);
        chk("rst_flags", {code_ext, code_brk}, 0);
        chk("rst_errs", {err_parity, err_frame, overflow}, 0);
        chk("rst_state", state_o, IDLE);
        rst = 1'b0;
        step(5);

        // Table of frames with ready held high.
        for (int i = 0; i < 15; i++) begin
            p0 = n_perr;
            f0 = n_ferr;
            if (vecs[i].exp_rec) exp_q.push_back(vecs[i].rec);
            send_frame(vecs[i].code, vecs[i].bad_par, 11, 1'b0);
            step(5);
            chk($sformatf("vec%0d_perr", i), n_perr - p0, vecs[i].exp_perr);
            chk($sformatf("vec%0d_ferr", i), n_ferr - f0, 0);
            chk($sformatf("vec%0d_pending", i), exp_q.size(), 0);
        end

        // Push-to-valid latency on an empty buffer, consumer stalled.
        code_ready = 1'b0;
        exp_q.push_back(10'h021);
        send_frame(8'h21, 1'b0, 11, 1'b1);
        step(5);
        code_ready = 1'b1;
        drain();

        // Timeout on a partial frame, then a clean frame.
        f0 = n_ferr;
        send_frame(8'h55, 1'b0, 5, 1'b0);
        step(250);
        chk("timeout_ferr", n_ferr - f0, 1);
        chk("timeout_state", state_o, IDLE);
        exp_q.push_back(10'h029);
        send_frame(8'h29, 1'b0, 11, 1'b0);
        drain();
        chk("after_timeout_ferr", n_ferr - f0, 1);

        // Buffer fill with stalled consumer, overflow, then ordered drain.
        code_ready = 1'b0;
        o0 = n_ovf;
        begin
            logic [7:0] ovf_codes[5];
            ovf_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
            for (int i = 0; i < 5; i++) begin
                if (i < EFF_DEPTH) exp_q.push_back({2'b00, ovf_codes[i]});
                send_frame(ovf_codes[i], 1'b0, 11, 1'b0);
            end
        end
        step(5);
        chk("ovf_count", n_ovf - o0, 5 - EFF_DEPTH);
        chk("ovf_head", {code_valid, code_ext, code_brk, code_data}, 11'h41C);
        code_ready = 1'b1;
        drain();
        step(2);
        chk("ovf_empty_after", code_valid, 0);

        // Reset mid-frame with records buffered.
        code_ready = 1'b0;
        exp_q.push_back(10'h01C);
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        if (EFF_DEPTH > 1) exp_q.push_back(10'h032);
        send_frame(8'h32, 1'b0, 11, 1'b0);
        send_frame(8'h44, 1'b0, 4, 1'b0);
        step(3);
        rst = 1'b1;
        #1;
        chk("midrst_valid", code_valid, 0);
        chk("midrst_state", state_o, IDLE);
        exp_q.delete();
        step(2);
        rst = 1'b0;
        code_ready = 1'b1;
        step(5);
        chk("postrst_valid", code_valid, 0);
        p0 = n_perr;
        exp_q.push_back(10'h01C);
        send_frame(8'h1C, 1'b0, 11, 1'b0);
        drain();
        chk("postrst_perr", n_perr - p0, 0);

        step(10);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_rx_ctrl.md
Name: ps2_rx_ctrl

Overview:
Keyboard receive controller that sequences the debounced PS/2 clock and data lines into scan-code records. It sits directly after the debouncer. It detects falling edges of the debounced keyboard clock and frames 11-bit packets (start, 8 data LSB-first, odd parity, stop). It folds E0/F0 prefixes into flags and presents finished records on a valid/ready interface, buffered through a small FIFO, to the game/display logic.

Parameters:
TIMEOUT_CYCLES, 50000, system clocks without a PS/2 clock fall before a partial frame is aborted.
FIFO_DEPTH, 4, record buffer entries; power of two, at least 2.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
ps2_clk_db  input  1  debounced keyboard clock
ps2_data_db  input  1  debounced keyboard data
code_data  output  8  scan code of head record
code_ext  output  1  head record was preceded by E0
code_brk  output  1  head record was preceded by F0 (key release)
code_valid  output  1  head record available
code_ready  input  1  consumer accepts head record when code_valid=1
err_parity  output  1  one-cycle pulse: parity or stop-bit failure
err_frame  output  1  one-cycle pulse: bad start bit or timeout
overflow  output  1  one-cycle pulse: record dropped, buffer full

Behaviour:
- Reset (async, rst=1): state IDLE, clk_q=1, bit count 0, shift register 0, ext/brk pending flags 0, timeout counter 0, FIFO empty. All outputs 0.
- Edge detect: clk_q <= ps2_clk_db each cycle. fall = clk_q & ~ps2_clk_db. ps2_data_db is sampled in the fall cycle.
- FSM, advancing only on fall:
  - IDLE: data=0 -> DATA, bit count 0. data=1 -> stay in IDLE, pulse err_frame.
  - DATA: shreg <= {data, shreg[7:1]}, count+1. After the 8th bit -> PARITY.
  - PARITY: capture p -> STOP.
  - STOP: if data=1 and (^shreg ^ p)=1, the frame is good: decode the byte. Otherwise pulse err_parity and clear both pending flags. Always -> IDLE.
- Timeout: counter clears on every fall and in IDLE; it increments otherwise. At TIMEOUT_CYCLES-1 in any non-IDLE state -> IDLE, pulse err_frame, clear pending flags. Counter width is $clog2(TIMEOUT_CYCLES).
- Decode of a good byte:
  - 8'hE0: set ext pending, no record.
  - 8'hF0: set brk pending, no record.
  - Any other byte: push {ext, brk, byte}, then clear both flags.
  - Repeated E0 or F0 leaves its flag set (idempotent).
- Latency: code_valid rises on the clock edge ending the cycle after the stop-bit fall cycle, when the FIFO was empty.
- Output handshake:
  - Pop when code_valid & code_ready.
  - code_data, code_ext and code_brk stay stable while valid and not popped.
  - Order is FIFO.
- Full with push and no pop: new record dropped, overflow pulses once, stored contents unchanged.
- Full with push and pop in the same cycle: both happen, no overflow.
- Empty with push: code_valid=1 next cycle. A pop with code_valid=0 is ignored.
- Reset mid-frame or with FIFO occupied: everything returns to reset values immediately and buffered records are lost.

Optional Feature:
PS2_RX_FIFO_EN:
- Defined: FIFO of FIFO_DEPTH entries as above.
- Undefined: a single holding register replaces the FIFO (FIFO_DEPTH ignored), with identical valid/ready, drop-on-full, overflow and push-with-pop rules (effective depth 1).

Decomposition:
- Package ps2_pkg:
  - State enum (IDLE, DATA, PARITY, STOP).
  - Constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - Packed record typedef {ext, brk, code[7:0]}.
- Sub-module ps2_code_fifo: synchronous FIFO of record type with push/pop/full/empty, instantiated only under PS2_RX_FIFO_EN.

Test Plan:
- Common bench settings: TIMEOUT_CYCLES=200; PS/2 half-period 20 clks.
- Frame 0x1C, p=0, stop=1, code_ready=1 -> one code_valid beat with code_data=0x1C, ext=0, brk=0; no error pulses.
- Frames F0 then 1C -> exactly one record: 0x1C with brk=1, ext=0. Frames E0, F0, 75 -> one record: 0x75 with ext=1, brk=1.
- Frame 0x1C with p=1, then 0x1C with p=0 -> err_parity pulses once, no record; second frame yields 0x1C with flags 0. F0 followed by a bad-parity frame, then 1C -> record has brk=0.
- Drive start plus 4 data bits, then idle 250 clks -> err_frame pulses once, FSM returns to IDLE; next good frame 0x29 decodes correctly.
- code_ready=0; send 1C, 32, 21, 23, 24 -> four records held, overflow pulses once at the fifth; raise code_ready -> 1C, 32, 21, 23 delivered in order, then code_valid=0. Repeat without PS2_RX_FIFO_EN -> only 1C held, overflow pulses four times.
- Assert rst mid-frame with 2 records buffered -> code_valid=0 immediately; the next complete frame decodes normally.
